melody_sequencer: RTL and testbench
===================================

// Module: melody_sequencer
// PURPOSE
//  Plays a fixed note sequence from an internal ROM and produces note_sel/note_gate.
//  Sits upstream of the tone selector / PWM path. note_sel feeds the selector; note_gate low mutes audio.
//  Supports start, stop and loop, a per-step duration and an articulation gap.
//  Ticks are derived internally from the 12 MHz system clock.
// PARAMETERS
//  TICK_DIV   750000  clk cycles per duration tick (16 ticks/s at 12 MHz); must be >=2
//  GAP_TICKS  1       silent ticks at the end of each non-rest note (0 or 1)
//  SONG_LEN   16      ROM depth in steps (max 16); step index wraps at SONG_LEN-1
// PORTS
//  clk        in   1  system clock, all logic on rising edge
//  reset      in   1  synchronous, active-low reset
//  start      in   1  1-cycle pulse: start, or restart from step 0
//  stop       in   1  1-cycle pulse: abort playback, go idle
//  loop_en    in   1  level: at end of song, restart at step 0 instead of finishing
//  note_sel   out  4  current note code for the tone selector
//  note_gate  out  1  1 = sound note_sel, 0 = mute (rest/gap/idle)
//  step_idx   out  4  ROM index of the step now playing
//  busy       out  1  1 while in PLAY or GAP
//  done       out  1  1-cycle pulse when the song finishes with loop_en=0
// BEHAVIOUR
//  ROM entry is 10 bits: {end, rest, note[3:0], dur[3:0]}. Step length is dur+1 ticks.
//  The ROM is a combinational case. Unlisted entries are END.
//  Default ROM: 0={0,0,0000,3} 1={0,0,0010,3} 2={0,1,0000,1} 3={0,0,0100,7} 4=END.
//  Reset (reset==0 at edge): state IDLE, note_sel=0, note_gate=0, step_idx=0, busy=0, done=0.
//    The prescaler and tick counters are also cleared. This takes effect mid-playback too.
//  Prescaler: counts 0..TICK_DIV-1 and emits tick on the terminal count.
//    It is cleared on any start, so the first tick is exactly TICK_DIV cycles after start.
//  States:
//    IDLE
//    PLAY: gate = ~rest
//    GAP: gate=0, note_sel held
//  IDLE -start-> PLAY: load entry 0 on the same edge.
//    The next cycle shows note_sel, note_gate=~rest, busy=1, and tick_cnt=dur.
//  PLAY, on tick: if tick_cnt==GAP_TICKS and rest==0 and GAP_TICKS==1 -> GAP.
//    Else if tick_cnt==0 -> advance. Else tick_cnt-1.
//  GAP, on tick: advance (tick_cnt reaches 0 on this tick).
//  advance: the next index is step_idx+1, wrapping to 0 after SONG_LEN-1.
//    If the next entry is END or the index wrapped:
//      loop_en=1 -> load entry 0, stay busy.
//      loop_en=0 -> IDLE, gate=0, busy=0, done=1 for 1 cycle.
//    Otherwise load the next entry into PLAY.
//  An END at step 0 while in IDLE: start gives one done pulse and no playback.
//  dur=0 with GAP_TICKS=1: a 1-tick note, no gap (gap never eats the whole note).
//  stop: -> IDLE next edge, gate=0, busy=0, no done pulse. Ignored when idle.
//  start while busy: restart at step 0 and clear the prescaler.
//  start and stop in the same cycle: stop wins.
//  note_sel keeps its last value in GAP, in rest and after finish; only reset clears it.
//  Latency: start -> first audible note_gate = 1 cycle.
// TESTING (sim with TICK_DIV=4, GAP_TICKS=1, default ROM)
//  1. Reset sequence:
//     hold reset=0 3 cycles, release -> all outputs 0, no tick activity.
//  2. Full song: start pulse at cycle 0.
//     Cycles 1-12: note_sel=0000, gate=1. Cycles 13-16: gate=0.
//     Cycles 17-28: note_sel=0010, gate=1. Cycles 29-32: gate=0.
//     Cycles 33-40: rest, gate=0, step_idx=2.
//     Cycles 41-68: note_sel=0100, gate=1. Cycles 69-72: gate=0.
//     Cycle 73: done=1, busy=0.
//  3. Loop: as test 2 with loop_en=1 -> at cycle 73, step_idx=0, note_sel=0000, gate=1, no done.
//  4. Stop mid-note at cycle 20 -> cycle 21: gate=0, busy=0, done=0, note_sel=0010 held.
//  5. Restart: start at cycle 0, start again at cycle 22 -> cycle 23: step_idx=0, note_sel=0000.
//     The next tick is at cycle 26.
//  6. Collisions: start+stop same cycle while busy -> IDLE.
//     reset=0 at cycle 30 -> cycle 31: all outputs 0.

Source files
------------

// File: rtl/melody_sequencer.sv
// Melody sequencer: plays a fixed ROM note sequence and drives note_sel/note_gate for the
// tone selector, with start/stop/loop control, per-step durations and an articulation gap.
module melody_sequencer #(
  parameter int unsigned TICK_DIV  = 750000,
  parameter int unsigned GAP_TICKS = 1,
  parameter int unsigned SONG_LEN  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       stop,
  input  logic       loop_en,
  output logic [3:0] note_sel,
  output logic       note_gate,
  output logic [3:0] step_idx,
  output logic       busy,
  output logic       done
);

  localparam int unsigned PW    = $clog2(TICK_DIV);
  localparam bit          GapEn = (GAP_TICKS == 1);

  typedef enum logic [1:0] {StIdle, StPlay, StGap} state_e;

  // Entry layout: {end, rest, note[3:0], dur[3:0]}; unlisted steps are END.
  function automatic logic [9:0] rom_entry(input logic [3:0] idx);
    logic [9:0] e;
    case (idx)
      4'd0:    e = {1'b0, 1'b0, 4'b0000, 4'd3};
      4'd1:    e = {1'b0, 1'b0, 4'b0010, 4'd3};
      4'd2:    e = {1'b0, 1'b1, 4'b0000, 4'd1};
      4'd3:    e = {1'b0, 1'b0, 4'b0100, 4'd7};
      default: e = {1'b1, 1'b0, 4'b0000, 4'd0};
    endcase
    return e;
  endfunction

  function automatic logic rom_is_end(input logic [3:0] idx);
    logic [9:0] e;
    e = rom_entry(idx);
    return e[9];
  endfunction

  state_e        r_state;
  logic [PW-1:0] r_presc;
  logic [3:0]    r_tick_cnt;
  logic          r_rest;

  logic       w_tick;
  logic       w_last;
  logic [3:0] w_next_idx;
  logic       w_wrap_end;
  logic [3:0] w_ld_idx;
  logic [9:0] w_ld_entry;
  logic       w_gap_now;
  logic       w_adv;
  logic       w_finish;

  assign w_tick     = (r_state != StIdle) && (r_presc == PW'(TICK_DIV - 1));
  assign w_last     = (step_idx == 4'(SONG_LEN - 1));
  assign w_next_idx = w_last ? 4'd0 : step_idx + 4'd1;
  assign w_wrap_end = w_last || rom_is_end(w_next_idx);
  // A start always reloads step 0; an advance that hits END or wraps also lands on step 0.
  assign w_ld_idx   = (start || w_wrap_end) ? 4'd0 : w_next_idx;
  assign w_ld_entry = rom_entry(w_ld_idx);
  // Gap only takes the last tick of a note longer than one tick, so it never eats the note.
  assign w_gap_now  = GapEn && !r_rest && (r_tick_cnt == 4'd1);
  assign w_adv      = w_tick && ((r_state == StGap) ||
                                 ((r_state == StPlay) && !w_gap_now && (r_tick_cnt == 4'd0)));
  assign w_finish   = w_ld_entry[9] || (!start && w_wrap_end && !loop_en);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= StIdle;
      r_presc    <= '0;
      r_tick_cnt <= '0;
      r_rest     <= 1'b0;
      note_sel   <= '0;
      note_gate  <= 1'b0;
      step_idx   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (w_tick || (r_state == StIdle)) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      if (stop) begin
        if (r_state != StIdle) begin
          r_state   <= StIdle;
          note_gate <= 1'b0;
          busy      <= 1'b0;
        end
      end else if (start || w_adv) begin
        if (start) begin
          r_presc <= '0;
        end
        if (w_finish) begin
          r_state   <= StIdle;
          note_gate <= 1'b0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else begin
          r_state    <= StPlay;
          step_idx   <= w_ld_idx;
          r_rest     <= w_ld_entry[8];
          note_gate  <= ~w_ld_entry[8];
          r_tick_cnt <= w_ld_entry[3:0];
          busy       <= 1'b1;
          if (!w_ld_entry[8]) begin
            note_sel <= w_ld_entry[7:4];
          end
        end
      end else if (w_tick && (r_state == StPlay)) begin
        if (w_gap_now) begin
          r_state    <= StGap;
          note_gate  <= 1'b0;
          r_tick_cnt <= 4'd0;
        end else begin
          r_tick_cnt <= r_tick_cnt - 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed bench for melody_sequencer with TICK_DIV=4 and the default ROM; expected output
// timelines are written out by hand from the song's step lengths.
module tb_melody_sequencer;

  logic       clk;
  logic       reset;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic [3:0] note_sel;
  logic       note_gate;
  logic [3:0] step_idx;
  logic       busy;
  logic       done;

  int n_checks;
  int n_fail;

  melody_sequencer #(
    .TICK_DIV (4),
    .GAP_TICKS(1),
    .SONG_LEN (16)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .note_sel (note_sel),
    .note_gate(note_gate),
    .step_idx (step_idx),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive pulses for the current cycle, then land 1 time unit after the edge.
  task automatic cyc(input logic s, input logic p);
    start = s;
    stop  = p;
    @(posedge clk);
    #1;
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) cyc(1'b0, 1'b0);
    reset = 1'b1;
  endtask

  // {busy, done, gate, step_idx, note_sel}
  function automatic logic [10:0] pk(logic b, logic d, logic g, logic [3:0] i, logic [3:0] n);
    return {b, d, g, i, n};
  endfunction

  function automatic logic [10:0] obs();
    return {busy, done, note_gate, step_idx, note_sel};
  endfunction

  // Hand timeline of the default song after a start pulse at cycle 0.
  function automatic logic [10:0] song_exp(int c);
    if (c <= 12) return pk(1, 0, 1, 4'd0, 4'b0000);
    if (c <= 16) return pk(1, 0, 0, 4'd0, 4'b0000);
    if (c <= 28) return pk(1, 0, 1, 4'd1, 4'b0010);
    if (c <= 32) return pk(1, 0, 0, 4'd1, 4'b0010);
    if (c <= 40) return pk(1, 0, 0, 4'd2, 4'b0010);
    if (c <= 68) return pk(1, 0, 1, 4'd3, 4'b0100);
    if (c <= 72) return pk(1, 0, 0, 4'd3, 4'b0100);
    return pk(0, 1, 0, 4'd3, 4'b0100);
  endfunction

  initial begin
    n_checks = 0;
    n_fail   = 0;
    start    = 1'b0;
    stop     = 1'b0;
    loop_en  = 1'b0;
    reset    = 1'b1;

    // Reset state, and nothing moves while idle.
    do_reset();
    cyc(1'b0, 1'b0);
    check("reset_outputs", 32'(obs()), 32'(pk(0, 0, 0, 4'd0, 4'd0)));
    repeat (10) cyc(1'b0, 1'b0);
    check("idle_quiet", 32'(obs()), 32'(pk(0, 0, 0, 4'd0, 4'd0)));
    cyc(1'b0, 1'b1);
    check("stop_idle_ignored", 32'(obs()), 32'(pk(0, 0, 0, 4'd0, 4'd0)));

    // Full song, every cycle compared against the timeline.
    cyc(1'b1, 1'b0);
    for (int c = 1; c <= 73; c++) begin
      check($sformatf("song_c%0d", c), 32'(obs()), 32'(song_exp(c)));
      cyc(1'b0, 1'b0);
    end
    check("done_one_cycle", 32'(obs()), 32'(pk(0, 0, 0, 4'd3, 4'b0100)));
    repeat (8) cyc(1'b0, 1'b0);
    check("after_finish_idle", 32'(obs()), 32'(pk(0, 0, 0, 4'd3, 4'b0100)));

    // Loop: wraps to step 0 at cycle 73 with no done pulse.
    do_reset();
    loop_en = 1'b1;
    cyc(1'b1, 1'b0);
    for (int c = 1; c < 73; c++) cyc(1'b0, 1'b0);
    check("loop_c73", 32'(obs()), 32'(pk(1, 0, 1, 4'd0, 4'b0000)));
    repeat (12) cyc(1'b0, 1'b0);
    check("loop_c85_gap", 32'(obs()), 32'(pk(1, 0, 0, 4'd0, 4'b0000)));
    loop_en = 1'b0;

    // Stop mid-note at cycle 20.
    do_reset();
    cyc(1'b1, 1'b0);
    for (int c = 1; c < 20; c++) cyc(1'b0, 1'b0);
    check("pre_stop_c20", 32'(obs()), 32'(pk(1, 0, 1, 4'd1, 4'b0010)));
    cyc(1'b0, 1'b1);
    check("stop_c21", 32'(obs()), 32'(pk(0, 0, 0, 4'd1, 4'b0010)));
    repeat (60) cyc(1'b0, 1'b0);
    check("stop_no_done", 32'(obs()), 32'(pk(0, 0, 0, 4'd1, 4'b0010)));

    // Restart at cycle 22; prescaler realigns so the first gap starts at cycle 35.
    do_reset();
    cyc(1'b1, 1'b0);
    for (int c = 1; c < 22; c++) cyc(1'b0, 1'b0);
    cyc(1'b1, 1'b0);
    check("restart_c23", 32'(obs()), 32'(pk(1, 0, 1, 4'd0, 4'b0000)));
    for (int c = 23; c < 34; c++) cyc(1'b0, 1'b0);
    check("restart_c34_gate", 32'(obs()), 32'(pk(1, 0, 1, 4'd0, 4'b0000)));
    cyc(1'b0, 1'b0);
    check("restart_c35_gap", 32'(obs()), 32'(pk(1, 0, 0, 4'd0, 4'b0000)));
    for (int c = 35; c < 39; c++) cyc(1'b0, 1'b0);
    check("restart_c39_step1", 32'(obs()), 32'(pk(1, 0, 1, 4'd1, 4'b0010)));

    // start+stop together while busy: stop wins.
    cyc(1'b1, 1'b1);
    check("start_stop_collide", 32'(obs()), 32'(pk(0, 0, 0, 4'd1, 4'b0010)));

    // Reset asserted mid-playback at cycle 30.
    cyc(1'b1, 1'b0);
    for (int c = 1; c < 30; c++) cyc(1'b0, 1'b0);
    check("pre_reset_c30", 32'(obs()), 32'(pk(1, 0, 0, 4'd1, 4'b0010)));
    reset = 1'b0;
    cyc(1'b0, 1'b0);
    check("reset_c31", 32'(obs()), 32'(pk(0, 0, 0, 4'd0, 4'd0)));
    reset = 1'b1;
    repeat (20) cyc(1'b0, 1'b0);
    check("post_reset_idle", 32'(obs()), 32'(pk(0, 0, 0, 4'd0, 4'd0)));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
